// File: rtl/servo_pwm_gen_pkg.sv
// Shared types and constants for the servo PWM generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: ramp state enum, bus widths, default 100 MHz timing,
// servo_flag bit positions and a 20-bit clamp helper.
package servo_pkg;

  localparam int DUTY_W = 19;   // duty value width (max 200000 fits)
  localparam int CNT_W  = 21;   // frame counter width (max 2000000 fits)
  localparam int EXT_W  = 20;   // ramp arithmetic width, one bit of headroom

  // Default timing at 100 MHz: 20 ms frame, 1.0-2.0 ms pulse, 1.5 ms centre.
  localparam int DEF_PERIOD      = 2000000;
  localparam int DEF_DUTY_MIN    = 100000;
  localparam int DEF_DUTY_MAX    = 200000;
  localparam int DEF_DUTY_CENTER = 150000;
  localparam int DEF_STEP        = 1000;

  // Bit positions inside servo_flag; lower index wins.
  localparam int FLAG_CTR = 0;
  localparam int FLAG_UP  = 1;
  localparam int FLAG_DN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_RAMP_CTR  = 2'd3
  } servo_state_e;

  // Clamp v into [lo, hi].
  function automatic logic [EXT_W-1:0] clamp20(input logic [EXT_W-1:0] v,
                                               input logic [EXT_W-1:0] lo,
                                               input logic [EXT_W-1:0] hi);
    logic [EXT_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_gen_frame_counter.sv
// Frame counter plus per-frame duty latch that shapes the PWM pulse.
// Latency: s_pulse_o is registered and aligned with the counter value.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   duty_nxt_i    duty the ramp logic will hold after this edge
//   frame_tick_o  high on the last cycle of every frame (cnt == PERIOD-1)
//   s_pulse_o     high for the first duty_active cycles of every frame
module servo_frame_counter
  import servo_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_CENTER = DEF_DUTY_CENTER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty_nxt_i,
  output logic              frame_tick_o,
  output logic              s_pulse_o
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_CENTER);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_act_q, duty_act_d;
  logic              pulse_q, pulse_d;

  assign frame_tick_o = (cnt_q == CNT_LAST);
  assign s_pulse_o    = pulse_q;

  always_comb begin
    cnt_d      = frame_tick_o ? '0 : cnt_q + CNT_W'(1);
    // The duty is only captured at the wrap, so a frame in flight never
    // changes width. Capturing the next-state duty means a step computed
    // on the last cycle of a frame shapes the very next frame.
    duty_act_d = frame_tick_o ? duty_nxt_i : duty_act_q;
    // Compare against next-state values so the registered pulse lines up
    // with cnt_q: high for cnt in [0, duty_active-1].
    pulse_d    = (CNT_W'(duty_act_d) > cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_act_q <= DUTY_RST;
      pulse_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_act_q <= duty_act_d;
      pulse_q    <= pulse_d;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: ramps the working duty toward a commanded target, one step per frame.
// Latency: command seen next cycle; duty steps on frame_tick; pin follows from the next frame.
// Backpressure: none; servo_flag is level-sampled every cycle.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   servo_flag   [0] centre, [1] ramp to DUTY_MAX, [2] ramp to DUTY_MIN ([0] highest priority)
//   s_pulse      registered PWM waveform
//   s_duty       current working duty in clk cycles
//   busy         high while a ramp is in progress
//   frame_tick   one-cycle pulse on the last cycle of each frame
//   duty_load, duty_in  (only with SERVO_PWM_DIRECT_LOAD_EN) direct clamped duty load
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_MIN    = DEF_DUTY_MIN,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int DUTY_CENTER = DEF_DUTY_CENTER,
  parameter int STEP        = DEF_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        servo_flag,
`ifdef SERVO_PWM_DIRECT_LOAD_EN
  input  logic              duty_load,
  input  logic [DUTY_W-1:0] duty_in,
`endif
  output logic              s_pulse,
  output logic [DUTY_W-1:0] s_duty,
  output logic              busy,
  output logic              frame_tick
);

  if (!((DUTY_MIN <= DUTY_CENTER) && (DUTY_CENTER <= DUTY_MAX) &&
        (DUTY_MAX < PERIOD) && (STEP >= 1))) begin : g_bad_params
    $error("servo_pwm_gen: need DUTY_MIN <= DUTY_CENTER <= DUTY_MAX < PERIOD and STEP >= 1");
  end

  localparam logic [EXT_W-1:0]  MIN_X  = EXT_W'(DUTY_MIN);
  localparam logic [EXT_W-1:0]  MAX_X  = EXT_W'(DUTY_MAX);
  localparam logic [EXT_W-1:0]  CTR_X  = EXT_W'(DUTY_CENTER);
  localparam logic [EXT_W-1:0]  STEP_X = EXT_W'(STEP);
  localparam logic [DUTY_W-1:0] MIN_D  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] CTR_D  = DUTY_W'(DUTY_CENTER);

  servo_state_e      state_q, state_d, state_sel;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [EXT_W-1:0]  duty_x, up_sum, up_val, dn_val, ctr_val;

  // Candidate next duties, all in 20 bits so the +STEP never wraps.
  always_comb begin
    duty_x = {1'b0, duty_q};
    up_sum = duty_x + STEP_X;
    up_val = (up_sum > MAX_X) ? MAX_X : up_sum;
    // Test before subtracting so the result never underflows.
    dn_val = (duty_x < MIN_X + STEP_X) ? MIN_X : duty_x - STEP_X;
    if (duty_x < CTR_X) begin
      ctr_val = (up_sum > CTR_X) ? CTR_X : up_sum;
    end else begin
      ctr_val = (duty_x < CTR_X + STEP_X) ? CTR_X : duty_x - STEP_X;
    end
  end

  always_comb begin
    // A new command overrides any ramp in progress; a command whose
    // target is already reached parks in IDLE, so a held flag cannot
    // re-trigger. With no flag set the current ramp carries on.
    state_sel = state_q;
    if (servo_flag[FLAG_CTR]) begin
      state_sel = (duty_q == CTR_D) ? ST_IDLE : ST_RAMP_CTR;
    end else if (servo_flag[FLAG_UP]) begin
      state_sel = (duty_q == MAX_D) ? ST_IDLE : ST_RAMP_UP;
    end else if (servo_flag[FLAG_DN]) begin
      state_sel = (duty_q == MIN_D) ? ST_IDLE : ST_RAMP_DOWN;
    end

    state_d = state_sel;
    duty_d  = duty_q;

    // Step only on the frame boundary; leave the ramp the same cycle the
    // target is reached so busy drops together with the final step.
    if (frame_tick) begin
      case (state_sel)
        ST_RAMP_UP: begin
          duty_d = DUTY_W'(up_val);
          if (up_val == MAX_X) state_d = ST_IDLE;
        end
        ST_RAMP_DOWN: begin
          duty_d = DUTY_W'(dn_val);
          if (dn_val == MIN_X) state_d = ST_IDLE;
        end
        ST_RAMP_CTR: begin
          duty_d = DUTY_W'(ctr_val);
          if (ctr_val == CTR_X) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

`ifdef SERVO_PWM_DIRECT_LOAD_EN
    // Direct load beats any command or ramp.
    if (duty_load) begin
      duty_d  = DUTY_W'(clamp20({1'b0, duty_in}, MIN_X, MAX_X));
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= CTR_D;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  assign s_duty = duty_q;
  assign busy   = (state_q != ST_IDLE);

  servo_frame_counter #(
    .PERIOD      (PERIOD),
    .DUTY_CENTER (DUTY_CENTER)
  ) u_frame (
    .clk          (clk),
    .rst          (rst),
    .duty_nxt_i   (duty_d),
    .frame_tick_o (frame_tick),
    .s_pulse_o    (s_pulse)
  );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a shortened frame.
// Latency: n/a.
// Backpressure: n/a.
module tb_servo_pwm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  servo_flag;
  logic        s_pulse;
  logic [18:0] s_duty;
  logic        busy;
  logic        frame_tick;
`ifdef SERVO_PWM_DIRECT_LOAD_EN
  logic        duty_load;
  logic [18:0] duty_in;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .PERIOD      (1000),
    .DUTY_MIN    (100),
    .DUTY_MAX    (200),
    .DUTY_CENTER (150),
    .STEP        (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .servo_flag (servo_flag),
`ifdef SERVO_PWM_DIRECT_LOAD_EN
    .duty_load  (duty_load),
    .duty_in    (duty_in),
`endif
    .s_pulse    (s_pulse),
    .s_duty     (s_duty),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_asrt++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until frame_tick is high (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    while (!frame_tick && n < 2000) begin
      step();
      n++;
    end
    if (!frame_tick) check("tick_timeout", 0, 1);
  endtask

  // Cross the next frame boundary; afterwards cnt == 0.
  task automatic tick_step();
    int n;
    wait_tick(n);
    step();
  endtask

  task automatic expect_tick(input string tag, input int duty, input int bsy);
    tick_step();
    check({tag, "_duty"}, int'(s_duty), duty);
    check({tag, "_busy"}, int'(busy), bsy);
  endtask

  // Count pulse-high cycles over one frame, starting at cnt == 0.
  task automatic meas(output int hi);
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      hi += int'(s_pulse);
      step();
    end
  endtask

  task automatic pulse_flag(input logic [2:0] f);
    servo_flag = f;
    step();
    servo_flag = 3'b000;
  endtask

  initial begin
    int n;
    int hi;
    rst        = 1'b1;
    servo_flag = 3'b000;
`ifdef SERVO_PWM_DIRECT_LOAD_EN
    duty_load  = 1'b0;
    duty_in    = '0;
`endif

    // 1: reset state and idle frames
    repeat (3) step();
    check("rst_duty", int'(s_duty), 150);
    check("rst_busy", int'(busy), 0);
    check("rst_pulse", int'(s_pulse), 0);
    check("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;
    wait_tick(n);
    check("first_tick_delay", n, 999);
    step();
    for (int f = 0; f < 3; f++) begin
      meas(hi);
      check("idle_hi", hi, 150);
    end
    check("idle_duty", int'(s_duty), 150);
    check("idle_busy", int'(busy), 0);

    // 2: ramp up, clamped at 200
    pulse_flag(3'b010);
    check("up_start_busy", int'(busy), 1);
    check("up_start_duty", int'(s_duty), 150);
    expect_tick("up1", 170, 1);
    expect_tick("up2", 190, 1);
    expect_tick("up3", 200, 0);
    meas(hi);
    check("up_hi", hi, 200);

    // 3: ramp down, clamped at 100
    pulse_flag(3'b100);
    expect_tick("dn1", 180, 1);
    expect_tick("dn2", 160, 1);
    expect_tick("dn3", 140, 1);
    expect_tick("dn4", 120, 1);
    expect_tick("dn5", 100, 0);
    expect_tick("dn_hold", 100, 0);
    meas(hi);
    check("dn_hi", hi, 100);

    // 4: centre ramp, override mid-ramp, priority with all flags held
    pulse_flag(3'b001);
    expect_tick("ctr1", 120, 1);
    expect_tick("ctr2", 140, 1);
    expect_tick("ctr3", 150, 0);
    pulse_flag(3'b100);
    expect_tick("ovr_dn", 130, 1);
    pulse_flag(3'b001);
    expect_tick("ovr_ctr", 150, 0);
    pulse_flag(3'b010);
    expect_tick("pri_up", 170, 1);
    servo_flag = 3'b111;
    expect_tick("pri_ctr", 150, 0);
    expect_tick("pri_held", 150, 0);
    servo_flag = 3'b000;

    // 5: reset mid-frame during a ramp
    pulse_flag(3'b010);
    expect_tick("r_up1", 170, 1);
    expect_tick("r_up2", 190, 1);
    expect_tick("r_up3", 200, 0);
    pulse_flag(3'b100);
    expect_tick("r_dn", 180, 1);
    repeat (300) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_duty", int'(s_duty), 150);
    check("mid_rst_pulse", int'(s_pulse), 0);
    check("mid_rst_busy", int'(busy), 0);
    wait_tick(n);
    check("mid_rst_cnt", n, 999);
    step();
    check("abandon_duty", int'(s_duty), 150);
    check("abandon_busy", int'(busy), 0);
    meas(hi);
    check("abandon_hi", hi, 150);

`ifdef SERVO_PWM_DIRECT_LOAD_EN
    // 6: direct load, clamped both ways, beats a ramp in progress
    pulse_flag(3'b100);
    check("ld_pre_busy", int'(busy), 1);
    duty_in   = 19'd250;
    duty_load = 1'b1;
    servo_flag = 3'b001;
    step();
    duty_load  = 1'b0;
    servo_flag = 3'b000;
    check("ld_hi_duty", int'(s_duty), 200);
    check("ld_hi_busy", int'(busy), 0);
    duty_in   = 19'd50;
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    check("ld_lo_duty", int'(s_duty), 100);
    check("ld_lo_busy", int'(busy), 0);
    tick_step();
    meas(hi);
    check("ld_pin_hi", hi, 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
